// File: rtl/signed_arith_pkg.sv
// Shared two's-complement helpers for the saturating arithmetic blocks.
package signed_arith_pkg;

  // Largest value a w-bit two's-complement number can hold.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Smallest value a w-bit two's-complement number can hold.
  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/signed_add_sat.sv
// Combinational signed add. Saturates to the rail on overflow and flags it.
module signed_add_sat
  import signed_arith_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sat_sum,
  output logic         ovf
);

  localparam logic [W-1:0] MAX_V = W'(sat_max(W));
  localparam logic [W-1:0] MIN_V = W'(sat_min(W));

  logic [W-1:0] s;

  assign s = a + b;
  // Overflow is only possible when both operands share a sign and the result flips it.
  assign ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  assign sat_sum = ovf ? (a[W-1] ? MIN_V : MAX_V) : s;

endmodule

// File: rtl/signed_frame_accum_sat.sv
// Sums N_BEATS signed samples per frame into a saturating accumulator.
// Emits one result per frame, with a sticky overflow flag, through a one-entry output register.
module signed_frame_accum_sat #(
  parameter int W       = 4,
  parameter int N_BEATS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] up_data,
  input  logic         up_vld,
  output logic         up_rdy,
  output logic [W-1:0] down_data,
  output logic         down_ovf,
  output logic         down_vld,
  input  logic         down_rdy
);

  localparam int CW = $clog2(N_BEATS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_BEATS - 1);

  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          sticky;

  logic          beat;
  logic [CW-1:0] cnt_eff;
  logic          last;
  logic [W-1:0]  acc_in;
  logic          sticky_in;
  logic [W-1:0]  sat_sum;
  logic          ovf;

  assign up_rdy = !down_vld || down_rdy;
  assign beat   = up_vld && up_rdy;

  // A clr arriving with a beat makes that beat the first of a fresh frame.
  assign cnt_eff   = clr ? '0 : cnt;
  assign last      = (cnt_eff == LAST);
  assign acc_in    = (cnt_eff == '0) ? '0 : acc;
  assign sticky_in = clr ? 1'b0 : sticky;

  signed_add_sat #(.W(W)) u_add (
    .a       (acc_in),
    .b       (up_data),
    .sat_sum (sat_sum),
    .ovf     (ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      down_data <= '0;
      down_ovf  <= 1'b0;
      down_vld  <= 1'b0;
    end else begin
      if (beat) begin
        if (last) begin
          down_data <= sat_sum;
          down_ovf  <= sticky_in | ovf;
          cnt       <= '0;
          sticky    <= 1'b0;
        end else begin
          acc    <= sat_sum;
          sticky <= sticky_in | ovf;
          cnt    <= cnt_eff + CW'(1);
        end
      end else if (clr) begin
        cnt    <= '0;
        sticky <= 1'b0;
      end

      // A frame end in the same cycle as a consume keeps the register full.
      if (beat && last)
        down_vld <= 1'b1;
      else if (down_rdy)
        down_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_signed_frame_accum_sat.sv
// Self-checking bench for signed_frame_accum_sat (W=4, N_BEATS=4) against a clamp-arithmetic model.
module tb_signed_frame_accum_sat;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] up_data = '0;
  logic       up_vld = 1'b0;
  logic       up_rdy;
  logic [3:0] down_data;
  logic       down_ovf;
  logic       down_vld;
  logic       down_rdy = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  signed_frame_accum_sat #(.W(4), .N_BEATS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .up_data   (up_data),
    .up_vld    (up_vld),
    .up_rdy    (up_rdy),
    .down_data (down_data),
    .down_ovf  (down_ovf),
    .down_vld  (down_vld),
    .down_rdy  (down_rdy)
  );

  always #5 clk = ~clk;

  // Reference: running integer sum clamped to [-8,7]; any clamp sets the flag.
  function automatic void ref_frame(input int s[4], output logic [3:0] sum_o, output logic ovf_o);
    int acc;
    acc = 0;
    ovf_o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc = acc + s[i];
      if (acc > 7) begin acc = 7; ovf_o = 1'b1; end
      else if (acc < -8) begin acc = -8; ovf_o = 1'b1; end
    end
    sum_o = 4'(acc);
  endfunction

  // Presents one sample and returns #1 after the edge that accepted it.
  task automatic send(input int x, input logic c);
    int waits;
    waits = 0;
    up_data = 4'(x);
    up_vld = 1'b1;
    clr = c;
    @(negedge clk);
    while (!up_rdy && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!up_rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout up_rdy=%b required 1", up_rdy);
    end
    @(posedge clk);
    #1;
    up_vld = 1'b0;
    clr = 1'b0;
  endtask

  task automatic send_frame(input int s[4]);
    for (int i = 0; i < 4; i++) send(s[i], 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    n_checks++;
    if (down_vld !== 1'b0 || down_data !== 4'd0 || down_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs vld=%b data=%0d ovf=%b required 0 0 0", down_vld, down_data, down_ovf);
    end
    n_checks++;
    if (up_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_up_rdy got %b required 1", up_rdy);
    end
  endtask

  task automatic test_basic;
    logic [3:0] es; logic eo;
    ref_frame('{3, 2, 1, 1}, es, eo);
    send_frame('{3, 2, 1, 1});
    n_checks++;
    if (down_vld !== 1'b1 || down_data !== es || down_ovf !== eo) begin
      n_fail++;
      $display("FAIL basic_result vld=%b data=%0d ovf=%b required 1 %0d %b", down_vld, down_data, down_ovf, es, eo);
    end
    idle(1);
    n_checks++;
    if (down_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_vld_one_cycle got %b required 0", down_vld);
    end
  endtask

  task automatic test_saturation;
    logic [3:0] es; logic eo;
    ref_frame('{5, 5, -3, 0}, es, eo);
    send_frame('{5, 5, -3, 0});
    n_checks++;
    if (down_vld !== 1'b1 || down_data !== es || down_ovf !== eo || es !== 4'd4) begin
      n_fail++;
      $display("FAIL sat_pos data=%0d ovf=%b required %0d %b", down_data, down_ovf, es, eo);
    end
    ref_frame('{-8, -1, 0, 0}, es, eo);
    send_frame('{-8, -1, 0, 0});
    n_checks++;
    if (down_data !== es || down_ovf !== eo) begin
      n_fail++;
      $display("FAIL sat_neg data=%0d ovf=%b required %0d %b", down_data, down_ovf, es, eo);
    end
    ref_frame('{1, 1, 1, 1}, es, eo);
    send_frame('{1, 1, 1, 1});
    n_checks++;
    if (down_data !== es || down_ovf !== eo) begin
      n_fail++;
      $display("FAIL sticky_cleared data=%0d ovf=%b required %0d %b", down_data, down_ovf, es, eo);
    end
    idle(1);
  endtask

  task automatic test_stall;
    logic [3:0] es; logic eo;
    ref_frame('{2, 2, -1, 3}, es, eo);
    send_frame('{2, 2, -1, 3});
    down_rdy = 1'b0;
    up_data = 4'd6;
    up_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (up_rdy !== 1'b0 || down_vld !== 1'b1 || down_data !== es || down_ovf !== eo) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d up_rdy=%b vld=%b data=%0d required 0 1 %0d", i, up_rdy, down_vld, down_data, es);
      end
    end
    @(posedge clk);
    #1;
    down_rdy = 1'b1;
    ref_frame('{6, 1, -2, 0}, es, eo);
    send(6, 1'b0);
    send(1, 1'b0);
    send(-2, 1'b0);
    send(0, 1'b0);
    n_checks++;
    if (down_vld !== 1'b1 || down_data !== es || down_ovf !== eo) begin
      n_fail++;
      $display("FAIL stall_resume data=%0d ovf=%b required %0d %b", down_data, down_ovf, es, eo);
    end
    idle(1);
  endtask

  task automatic test_back_to_back;
    logic [3:0] es1, es2; logic eo1, eo2;
    int t0;
    ref_frame('{7, 1, 0, -2}, es1, eo1);
    ref_frame('{-4, -4, -4, 3}, es2, eo2);
    t0 = $time;
    send_frame('{7, 1, 0, -2});
    n_checks++;
    if (down_vld !== 1'b1 || down_data !== es1 || down_ovf !== eo1) begin
      n_fail++;
      $display("FAIL b2b_first vld=%b data=%0d ovf=%b required 1 %0d %b", down_vld, down_data, down_ovf, es1, eo1);
    end
    send_frame('{-4, -4, -4, 3});
    n_checks++;
    if (down_vld !== 1'b1 || down_data !== es2 || down_ovf !== eo2) begin
      n_fail++;
      $display("FAIL b2b_second vld=%b data=%0d ovf=%b required 1 %0d %b", down_vld, down_data, down_ovf, es2, eo2);
    end
    n_checks++;
    if ($time - t0 > 80) begin
      n_fail++;
      $display("FAIL b2b_no_bubbles elapsed=%0d required <=80", $time - t0);
    end
    idle(1);
  endtask

  task automatic test_clr;
    logic [3:0] es; logic eo;
    send(3, 1'b0);
    send(3, 1'b0);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    ref_frame('{1, 1, 1, 1}, es, eo);
    send_frame('{1, 1, 1, 1});
    n_checks++;
    if (down_data !== es || down_ovf !== eo) begin
      n_fail++;
      $display("FAIL clr_idle data=%0d ovf=%b required %0d %b", down_data, down_ovf, es, eo);
    end
    send(-5, 1'b0);
    ref_frame('{2, 2, 2, 2}, es, eo);
    send(2, 1'b1);
    send(2, 1'b0);
    send(2, 1'b0);
    send(2, 1'b0);
    n_checks++;
    if (down_vld !== 1'b1 || down_data !== es || down_ovf !== eo || es !== 4'd7) begin
      n_fail++;
      $display("FAIL clr_with_beat data=%0d ovf=%b required %0d %b", down_data, down_ovf, es, eo);
    end
    idle(1);
  endtask

  task automatic test_reset_mid;
    logic [3:0] es; logic eo;
    send(4, 1'b0);
    send(2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (down_vld !== 1'b0 || down_data !== 4'd0 || down_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_partial vld=%b data=%0d ovf=%b required 0 0 0", down_vld, down_data, down_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    ref_frame('{1, 2, 1, 1}, es, eo);
    send_frame('{1, 2, 1, 1});
    n_checks++;
    if (down_vld !== 1'b1 || down_data !== es || down_ovf !== eo) begin
      n_fail++;
      $display("FAIL rst_fresh_frame vld=%b data=%0d required 1 %0d", down_vld, down_data, es);
    end
    down_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (down_vld !== 1'b0 || down_data !== 4'd0 || down_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_held vld=%b data=%0d ovf=%b required 0 0 0", down_vld, down_data, down_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    down_rdy = 1'b1;
    idle(1);
    ref_frame('{-3, -3, -3, 5}, es, eo);
    send_frame('{-3, -3, -3, 5});
    n_checks++;
    if (down_vld !== 1'b1 || down_data !== es || down_ovf !== eo) begin
      n_fail++;
      $display("FAIL rst_after_held data=%0d ovf=%b required %0d %b", down_data, down_ovf, es, eo);
    end
    idle(1);
  endtask

  task automatic test_random;
    int s[4];
    int junk;
    logic [3:0] es; logic eo;
    for (int f = 0; f < 40; f++) begin
      junk = $urandom_range(0, 3);
      for (int j = 0; j < junk; j++) send($urandom_range(0, 15) - 8, 1'b0);
      for (int i = 0; i < 4; i++) s[i] = $urandom_range(0, 15) - 8;
      ref_frame(s, es, eo);
      send(s[0], junk != 0);
      for (int i = 1; i < 4; i++) send(s[i], 1'b0);
      n_checks++;
      if (down_vld !== 1'b1 || down_data !== es || down_ovf !== eo) begin
        n_fail++;
        $display("FAIL random_frame f=%0d data=%0d ovf=%b required %0d %b", f, down_data, down_ovf, es, eo);
      end
      down_rdy = $urandom_range(0, 1);
      idle($urandom_range(0, 3));
      down_rdy = 1'b1;
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_stall();
    test_back_to_back();
    test_clr();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
